sr_frame_tx: RTL and testbench
==============================

Name: sr_frame_tx

Overview:
- Serial frame transmitter for daisy-chained serial-in/parallel-out shift registers (74HC595-style), e.g. the 5x8 indicator LED array beside the IR sensor grid.
- It is the write direction of the sensor-chain read interface: it drives sclk, sdo and latch, where the sensor reader consumes sdi.
- Accepts one WIDTH-bit frame over a valid/ready handshake, shifts it out MSB first at a clk_en-paced bit rate, then pulses latch to transfer the frame to the outputs.

Parameters:
- WIDTH, 40: frame length in bits; one bit per array cell, row 0 in bits [WIDTH-1:WIDTH-8].
- DIV, 1: clk_en ticks per sclk half-period; legal range >= 1.
- INVERT, 0: when 1, every data bit is complemented before transmission (active-low LEDs).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- clk_en  input  1  tick qualifier; the serial timing advances only on cycles where clk_en=1.
- frame_valid  input  1  frame_data is valid.
- frame_data  input  WIDTH  frame to send; bit WIDTH-1 is sent first.
- frame_ready  output  1  high exactly when state is IDLE; handshake completes when frame_valid & frame_ready on a clk edge, independent of clk_en.
- sclk  output  1  registered serial clock; idles high; downstream samples on its rising edge.
- sdo  output  1  registered serial data.
- latch  output  1  registered storage-latch pulse, active high.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-clk pulse when a frame's latch pulse completes.
- state_out  output  2  current state encoding: IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3.

Behaviour:
- Reset (rst=1 on a clk edge, wins over everything):
  - state=IDLE; sclk=1, sdo=0, latch=0, done=0.
  - Shift register, bit counter and divider counter all cleared.
  - Takes effect mid-frame too: the partial frame is abandoned, latch is never pulsed and done is not asserted.
- Divider: div_cnt counts clk_en ticks within the current state. The state "expires" on the tick where div_cnt==DIV-1; div_cnt is cleared on every state change.
- IDLE:
  - sclk=1, latch=0.
  - On handshake: shreg <= frame_data ^ {WIDTH{INVERT}}; sdo <= that value's MSB; sclk <= 0; bit_cnt <= 0; go to SHIFT_LO.
  - frame_data is captured only at the handshake; later changes are ignored.
- SHIFT_LO: sclk held low, sdo stable. On expiry: sclk <= 1 (rising edge = sample point); go to SHIFT_HI.
- SHIFT_HI, on expiry:
  - If bit_cnt==WIDTH-1: sclk stays 1; latch <= 1; go to LATCH.
  - Otherwise: sclk <= 0; shreg shifts left; sdo <= next bit; bit_cnt++; go to SHIFT_LO.
- sdo timing: sdo changes only on the same edge that drives sclk low, so it is stable for a full high + low half-period around each rising edge.
- LATCH: latch high for DIV ticks. On expiry: latch <= 0; done <= 1 for one clk; go to IDLE.
- Counts and latency:
  - Exactly WIDTH sclk rising edges per frame; exactly one latch pulse per frame.
  - From the handshake edge to the done pulse: (2*WIDTH+1)*DIV ticks.
  - With clk_en tied high, WIDTH=40, DIV=1: done is high in the 81st cycle after the handshake edge.
- Back-to-back frames:
  - done and frame_ready are both high in the first IDLE cycle, so a new handshake there is legal.
  - The new frame's first sclk fall is on that same edge; there is no dead time.
- Busy and clk_en rules:
  - frame_valid while busy: ignored; frame_ready=0; nothing is queued.
  - clk_en=0 freezes all serial outputs and counters. The handshake and rst still act.
- Widths: bit_cnt is $clog2(WIDTH) bits; div_cnt is $clog2(DIV)+1 bits; no counter ever wraps in legal operation.

Test Plan:
- Basic frame (WIDTH=40, DIV=1, INVERT=0, clk_en=1): send 40'hA50FF01280 -> bits sampled at sclk rising edges equal 40'hA50FF01280 MSB first; exactly 40 rising edges; one latch pulse 1 cycle wide; done in cycle 81; frame_ready low during cycles 1-80.
- Invert (INVERT=1): send 40'h0000000001 -> 39 ones then a final 0 sampled; the latch and done timing are unchanged.
- Pacing (DIV=2, clk_en high 1 cycle in 4): send 40'hFFFFFFFFFF -> each sclk half-period lasts 8 clk; done arrives 81*2*4=648 cycles after the handshake; all 40 sampled bits are 1.
- Busy rejection: hold frame_valid with 40'h123456789A during the whole transfer of frame 40'h00000000FF -> only 40'h00000000FF is shifted. The held frame is accepted in the done cycle and transmitted next, with no gap.
- Reset mid-frame: assert rst for 1 cycle after the 17th sclk rise -> next cycle sclk=1, sdo=0, latch=0, busy=0, frame_ready=1; no latch pulse and no done for the aborted frame.
- Loopback: feed sclk/latch/sdo into a 40-bit behavioural SIPO model -> its parallel output equals the sent frame after each latch, for 3 random frames.

Source files
------------

// File: rtl/sr_frame_tx.sv
// Serial frame transmitter for daisy-chained 74HC595-style SIPO chains.
// Shifts a WIDTH-bit frame out MSB first, then pulses latch.
module sr_frame_tx #(
  parameter int WIDTH  = 40,
  parameter int DIV    = 1,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             frame_valid,
  input  logic [WIDTH-1:0] frame_data,
  output logic             frame_ready,
  output logic             sclk,
  output logic             sdo,
  output logic             latch,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_out
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = $clog2(DIV) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;
  logic             latch_q, latch_d;
  logic             done_q, done_d;

  logic             hs;
  logic             expire;
  logic             last_bit;
  logic [WIDTH-1:0] frame_x;

  assign hs       = frame_valid && (state_q == IDLE);
  assign expire   = clk_en && (div_cnt_q == DW'(DIV - 1));
  assign last_bit = (bit_cnt_q == BW'(WIDTH - 1));
  assign frame_x  = frame_data ^ {WIDTH{INVERT}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (hs) state_d = SHIFT_LO;
      SHIFT_LO: if (expire) state_d = SHIFT_HI;
      SHIFT_HI: if (expire) state_d = last_bit ? LATCH : SHIFT_LO;
      LATCH:    if (expire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Divider restarts on every state change so each phase lasts DIV ticks.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (state_d != state_q) begin
      div_cnt_d = '0;
    end else if (state_q != IDLE && clk_en) begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    latch_d   = latch_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d  = 1'b1;
        latch_d = 1'b0;
        if (hs) begin
          shreg_d   = frame_x;
          sdo_d     = frame_x[WIDTH-1];
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end
      SHIFT_LO: begin
        if (expire) sclk_d = 1'b1;
      end
      SHIFT_HI: begin
        if (expire) begin
          if (last_bit) begin
            latch_d = 1'b1;
          end else begin
            // sdo only moves on the falling sclk edge
            sclk_d    = 1'b0;
            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            sdo_d     = shreg_q[WIDTH-2];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      LATCH: begin
        if (expire) begin
          latch_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        sclk_d  = 1'b1;
        latch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b1;
      sdo_q     <= 1'b0;
      latch_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      latch_q   <= latch_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    frame_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    state_out   = state_q;
    sclk        = sclk_q;
    sdo         = sdo_q;
    latch       = latch_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_sr_frame_tx.sv
// Bench for sr_frame_tx: three instances (plain, inverted, paced DIV=2)
// observed through a behavioural SIPO model.
module tb_sr_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  valid_w;
  logic [39:0] data_w [3];
  logic        ce_c;
  logic        ce_ab;
  logic [2:0]  ready_w, sclk_w, sdo_w, latch_w, busy_w, done_w;
  logic [1:0]  st_w [3];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ce_c  = (cyc[1:0] == 2'b11);
  assign ce_ab = 1'b1;

  sr_frame_tx #(.WIDTH(40), .DIV(1), .INVERT(1'b0)) u_a (
    .clk(clk), .rst(rst), .clk_en(ce_ab),
    .frame_valid(valid_w[0]), .frame_data(data_w[0]),
    .frame_ready(ready_w[0]), .sclk(sclk_w[0]), .sdo(sdo_w[0]),
    .latch(latch_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .state_out(st_w[0])
  );

  sr_frame_tx #(.WIDTH(40), .DIV(1), .INVERT(1'b1)) u_b (
    .clk(clk), .rst(rst), .clk_en(ce_ab),
    .frame_valid(valid_w[1]), .frame_data(data_w[1]),
    .frame_ready(ready_w[1]), .sclk(sclk_w[1]), .sdo(sdo_w[1]),
    .latch(latch_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .state_out(st_w[1])
  );

  sr_frame_tx #(.WIDTH(40), .DIV(2), .INVERT(1'b0)) u_c (
    .clk(clk), .rst(rst), .clk_en(ce_c),
    .frame_valid(valid_w[2]), .frame_data(data_w[2]),
    .frame_ready(ready_w[2]), .sclk(sclk_w[2]), .sdo(sdo_w[2]),
    .latch(latch_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .state_out(st_w[2])
  );

  // SIPO model plus edge statistics, sampled mid-cycle
  logic [39:0] sh  [3];
  logic [39:0] par [3];
  int rises [3], latches [3], dones [3];
  int lrun [3], llen [3], lastr [3], gap [3];
  logic [2:0] psclk = '0;
  logic [2:0] plat  = '0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      sh[i] = '0; par[i] = '0; rises[i] = 0; latches[i] = 0;
      dones[i] = 0; lrun[i] = 0; llen[i] = 0; lastr[i] = 0; gap[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sclk_w[i] === 1'b1 && !psclk[i]) begin
        rises[i] <= rises[i] + 1;
        sh[i]    <= {sh[i][38:0], sdo_w[i]};
        gap[i]   <= cyc - lastr[i];
        lastr[i] <= cyc;
      end
      if (latch_w[i] === 1'b1) begin
        lrun[i] <= lrun[i] + 1;
        if (!plat[i]) begin
          latches[i] <= latches[i] + 1;
          par[i]     <= sh[i];
        end
      end else if (plat[i]) begin
        llen[i] <= lrun[i];
        lrun[i] <= 0;
      end
      if (done_w[i] === 1'b1) dones[i] <= dones[i] + 1;
      psclk[i] <= (sclk_w[i] === 1'b1);
      plat[i]  <= (latch_w[i] === 1'b1);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  typedef struct {
    int          inst;
    logic [39:0] data;
    logic [39:0] exp_bits;
    int          exp_lat;
    int          exp_llen;
    int          exp_gap;
  } vec_t;

  task automatic run_vec(input int k, input vec_t v);
    int i, r0, l0, hs, t, bad;
    string tag;
    i = v.inst;
    tag = $sformatf("v%0d", k);
    tick();
    r0 = rises[i];
    l0 = latches[i];
    if (i == 2) begin
      t = 0;
      while (!ce_c && t < 8) begin tick(); t++; end
    end
    data_w[i]  = v.data;
    valid_w[i] = 1'b1;
    @(posedge clk);
    #1;
    valid_w[i] = 1'b0;
    data_w[i]  = ~v.data;
    hs = cyc;
    bad = 0;
    t = 0;
    tick();
    while (!done_w[i] && t < 2000) begin
      if (ready_w[i]) bad++;
      t++;
      tick();
    end
    chk({tag, "_latency"}, 64'(cyc - hs), 64'(v.exp_lat));
    chk({tag, "_ready_busy"}, 64'(bad), 64'd0);
    chk({tag, "_ready_done"}, 64'(ready_w[i]), 64'd1);
    tick();
    chk({tag, "_bits"}, 64'(sh[i]), 64'(v.exp_bits));
    chk({tag, "_sipo"}, 64'(par[i]), 64'(v.exp_bits));
    chk({tag, "_rises"}, 64'(rises[i] - r0), 64'd40);
    chk({tag, "_latches"}, 64'(latches[i] - l0), 64'd1);
    chk({tag, "_latch_len"}, 64'(llen[i]), 64'(v.exp_llen));
    chk({tag, "_sclk_period"}, 64'(gap[i]), 64'(v.exp_gap));
  endtask

  vec_t tbl [7];

  initial begin
    int t, r0, l0, d0, k0, dn0;
    logic [63:0] rnd;
    tbl[0] = '{0, 40'hA50FF01280, 40'hA50FF01280, 81, 1, 2};
    tbl[1] = '{1, 40'h0000000001, 40'hFFFFFFFFFE, 81, 1, 2};
    tbl[2] = '{2, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 648, 8, 16};
    tbl[3] = '{1, 40'hF0F0F0F0F0, 40'h0F0F0F0F0F, 81, 1, 2};
    for (int j = 4; j < 7; j++) begin
      rnd = {$urandom(), $urandom()};
      tbl[j] = '{0, rnd[39:0], rnd[39:0], 81, 1, 2};
    end

    rst = 1'b1;
    valid_w = '0;
    for (int i = 0; i < 3; i++) data_w[i] = '0;
    repeat (3) @(posedge clk);
    tick();
    chk("rst_sclk", 64'(sclk_w), 64'h7);
    chk("rst_sdo", 64'(sdo_w), 64'h0);
    chk("rst_latch", 64'(latch_w), 64'h0);
    chk("rst_done", 64'(done_w), 64'h0);
    chk("rst_ready", 64'(ready_w), 64'h7);
    chk("rst_busy", 64'(busy_w), 64'h0);
    chk("rst_state", 64'(st_w[0]), 64'h0);
    rst = 1'b0;
    repeat (3) tick();

    for (int j = 0; j < 7; j++) run_vec(j, tbl[j]);

    // A frame held valid during a transfer is taken in the done cycle
    tick();
    r0 = rises[0];
    l0 = latches[0];
    data_w[0]  = 40'h00000000FF;
    valid_w[0] = 1'b1;
    @(posedge clk);
    #1;
    data_w[0] = 40'h123456789A;
    t = 0;
    tick();
    while (!done_w[0] && t < 2000) begin t++; tick(); end
    chk("busy_first_bits", 64'(sh[0]), 64'h00000000FF);
    chk("busy_first_rises", 64'(rises[0] - r0), 64'd40);
    chk("busy_ready_done", 64'(ready_w[0]), 64'd1);
    d0 = cyc;
    @(posedge clk);
    #1;
    valid_w[0] = 1'b0;
    tick();
    chk("nogap_state", 64'(st_w[0]), 64'd1);
    chk("nogap_sclk", 64'(sclk_w[0]), 64'd0);
    chk("nogap_sdo", 64'(sdo_w[0]), 64'd0);
    t = 0;
    while (!done_w[0] && t < 2000) begin t++; tick(); end
    chk("busy_second_lat", 64'(cyc - d0), 64'd82);
    tick();
    chk("busy_second_bits", 64'(sh[0]), 64'h123456789A);
    chk("busy_latches", 64'(latches[0] - l0), 64'd2);
    chk("busy_rises", 64'(rises[0] - r0), 64'd80);

    // Abort after the 17th rising sclk edge
    tick();
    r0 = rises[0];
    l0 = latches[0];
    dn0 = dones[0];
    data_w[0]  = 40'hC3A55A3C96;
    valid_w[0] = 1'b1;
    @(posedge clk);
    #1;
    valid_w[0] = 1'b0;
    t = 0;
    tick();
    while (rises[0] - r0 < 17 && t < 200) begin t++; tick(); end
    chk("abort_reach17", 64'(rises[0] - r0), 64'd17);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("abort_sclk", 64'(sclk_w[0]), 64'd1);
    chk("abort_sdo", 64'(sdo_w[0]), 64'd0);
    chk("abort_latch", 64'(latch_w[0]), 64'd0);
    chk("abort_busy", 64'(busy_w[0]), 64'd0);
    chk("abort_ready", 64'(ready_w[0]), 64'd1);
    k0 = rises[0];
    repeat (100) tick();
    chk("abort_no_latch", 64'(latches[0] - l0), 64'd0);
    chk("abort_no_done", 64'(dones[0] - dn0), 64'd0);
    chk("abort_no_rise", 64'(rises[0] - k0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
